hot_buffer_sched: RTL

HOT_BUFFER_SCHED -- requirements
Module: hot_buffer_sched

---
 rtl/hot_buffer_sched_if.sv | 33 +++
 rtl/hot_buffer_sched.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/hot_buffer_sched_if.sv
// rtl/hot_buffer_sched_if.sv - requester and hot-buffer signals of hot_buffer_sched
interface hot_buffer_sched_if #(
  parameter int IDX_W = 8,
  parameter int LEN_W = 9
);
  logic             wr_req;
  logic [IDX_W-1:0] wr_base;
  logic [LEN_W-1:0] wr_len;
  logic             wr_grant;
  logic             wr_done;
  logic             rd_req;
  logic [IDX_W-1:0] rd_base;
  logic [LEN_W-1:0] rd_len;
  logic             rd_grant;
  logic             rd_done;
  logic             rd_data_valid;
  logic [IDX_W-1:0] buf_idx;
  logic             buf_write_en;
  logic             buf_read_en;
  logic             busy;

  modport master (
    output wr_req, wr_base, wr_len, rd_req, rd_base, rd_len,
    input  wr_grant, wr_done, rd_grant, rd_done, rd_data_valid,
    input  buf_idx, buf_write_en, buf_read_en, busy
  );

  modport slave (
    input  wr_req, wr_base, wr_len, rd_req, rd_base, rd_len,
    output wr_grant, wr_done, rd_grant, rd_done, rd_data_valid,
    output buf_idx, buf_write_en, buf_read_en, busy
  );
endinterface

// File: rtl/hot_buffer_sched.sv
// rtl/hot_buffer_sched.sv - fill/read burst scheduler for the hot buffer
// Define HOT_BUFFER_SCHED_RR_EN for round-robin arbitration; default is fill-first.
module hot_buffer_sched #(
  parameter int IDX_W = 8,
  parameter int LEN_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  hot_buffer_sched_if.slave bus
);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << IDX_W);

  typedef enum logic [1:0] {IDLE, FILL, READ} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_grant_q, wr_grant_d;
  logic             rd_grant_q, rd_grant_d;
  logic             wr_done_q, wr_done_d;
  logic             rd_done_q, rd_done_d;
  logic             we_q, we_d;
  logic             re_q, re_d;
  logic             rdv_q, rdv_d;
  logic             busy_q, busy_d;
  logic             pick_wr, pick_rd;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > MAX_LEN) ? MAX_LEN : l;
  endfunction

`ifdef HOT_BUFFER_SCHED_RR_EN
  logic last_rd_q, last_rd_d;
  assign pick_wr = bus.wr_req && (!bus.rd_req || last_rd_q);
`else
  assign pick_wr = bus.wr_req;
`endif
  assign pick_rd = bus.rd_req && !pick_wr;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    beat_d     = beat_q;
    idx_d      = idx_q;
    wr_grant_d = 1'b0;
    rd_grant_d = 1'b0;
    wr_done_d  = 1'b0;
    rd_done_d  = 1'b0;
    we_d       = 1'b0;
    re_d       = 1'b0;
    rdv_d      = re_q;
    busy_d     = 1'b0;
`ifdef HOT_BUFFER_SCHED_RR_EN
    last_rd_d  = last_rd_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_wr) begin
          wr_grant_d = 1'b1;
          base_d     = bus.wr_base;
          len_d      = clamp_len(bus.wr_len);
          beat_d     = '0;
          state_d    = FILL;
`ifdef HOT_BUFFER_SCHED_RR_EN
          last_rd_d  = 1'b0;
`endif
        end else if (pick_rd) begin
          rd_grant_d = 1'b1;
          base_d     = bus.rd_base;
          len_d      = clamp_len(bus.rd_len);
          beat_d     = '0;
          state_d    = READ;
`ifdef HOT_BUFFER_SCHED_RR_EN
          last_rd_d  = 1'b1;
`endif
        end
      end
      FILL, READ: begin
        busy_d = 1'b1;
        // The done edge lands one beat after the last enable, which is also where the last read strobe appears.
        if (beat_q == len_q) begin
          wr_done_d = (state_q == FILL);
          rd_done_d = (state_q == READ);
          state_d   = IDLE;
        end else begin
          we_d   = (state_q == FILL);
          re_d   = (state_q == READ);
          idx_d  = base_q + beat_q[IDX_W-1:0];
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      idx_q      <= '0;
      wr_grant_q <= 1'b0;
      rd_grant_q <= 1'b0;
      wr_done_q  <= 1'b0;
      rd_done_q  <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      rdv_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef HOT_BUFFER_SCHED_RR_EN
      last_rd_q  <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      idx_q      <= idx_d;
      wr_grant_q <= wr_grant_d;
      rd_grant_q <= rd_grant_d;
      wr_done_q  <= wr_done_d;
      rd_done_q  <= rd_done_d;
      we_q       <= we_d;
      re_q       <= re_d;
      rdv_q      <= rdv_d;
      busy_q     <= busy_d;
`ifdef HOT_BUFFER_SCHED_RR_EN
      last_rd_q  <= last_rd_d;
`endif
    end
  end

  assign bus.wr_grant      = wr_grant_q;
  assign bus.rd_grant      = rd_grant_q;
  assign bus.wr_done       = wr_done_q;
  assign bus.rd_done       = rd_done_q;
  assign bus.buf_write_en  = we_q;
  assign bus.buf_read_en   = re_q;
  assign bus.rd_data_valid = rdv_q;
  assign bus.buf_idx       = idx_q;
  assign bus.busy          = busy_q;
endmodule
